// File: rtl/fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage : IF stage with request/valid imem port and IF/ID    |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [3:0] HLT_OP = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] nxt_addr,
  input  logic        taken,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] curr_addr,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_DISCARD = 2'd1,
    S_FULL    = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_hold;
  logic        r_ifid_valid;
  logic [15:0] r_ifid_instr;
  logic [15:0] r_ifid_pc;
  logic [15:0] w_pc_inc;
  logic        w_outstanding;

  assign w_pc_inc = r_pc + 16'd2;
  // A response is still owed after this cycle if one was pending and none arrived.
  assign w_outstanding = ((r_state == S_REQ) || (r_state == S_DISCARD)) && !imem_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= 16'h0000;
      r_hold       <= 16'h0000;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= 16'h0000;
      r_ifid_pc    <= 16'h0000;
    end else if (taken) begin
      r_pc         <= nxt_addr;
      r_ifid_valid <= 1'b0;
      r_hold       <= 16'h0000;
      r_state      <= w_outstanding ? S_DISCARD : S_REQ;
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (imem_valid) begin
            if (stall) begin
              r_hold  <= imem_rdata;
              r_state <= S_FULL;
            end else begin
              r_ifid_valid <= 1'b1;
              r_ifid_instr <= imem_rdata;
              r_ifid_pc    <= r_pc;
              r_pc         <= w_pc_inc;
              r_state      <= (imem_rdata[15:12] == HLT_OP) ? S_HALT : S_REQ;
            end
          end else if (!stall) begin
            r_ifid_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (!stall) begin
            r_ifid_valid <= 1'b1;
            r_ifid_instr <= r_hold;
            r_ifid_pc    <= r_pc;
            r_pc         <= w_pc_inc;
            r_state      <= (r_hold[15:12] == HLT_OP) ? S_HALT : S_REQ;
          end
        end
        S_DISCARD: begin
          if (imem_valid) begin
            r_state <= S_REQ;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_REQ;
        end
      endcase
    end
  end

  assign imem_req   = ((r_state == S_REQ) || (r_state == S_DISCARD)) && !rst;
  assign halted     = (r_state == S_HALT) && !rst;
  assign imem_addr  = r_pc;
  assign curr_addr  = r_pc;
  assign ifid_valid = r_ifid_valid;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc    = r_ifid_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// Directed bench for fetch_stage: hand-computed expectations checked with immediate assertions.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [15:0] nxt_addr;
  logic        taken;
  logic        stall;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] curr_addr;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.HLT_OP(4'hF)) dut (
    .clk        (clk),
    .rst        (rst),
    .nxt_addr   (nxt_addr),
    .taken      (taken),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .curr_addr  (curr_addr),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic t, input logic [15:0] na, input logic s,
                       input logic v, input logic [15:0] rd);
    taken = t; nxt_addr = na; stall = s; imem_valid = v; imem_rdata = rd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc();
    cyc();
    // Reset state
    chk("rst_pc",        curr_addr, 16'h0000);
    chk("rst_ifid_v",    {15'b0, ifid_valid}, 16'h0);
    chk("rst_ifid_i",    ifid_instr, 16'h0000);
    chk("rst_ifid_pc",   ifid_pc, 16'h0000);
    chk("rst_req",       {15'b0, imem_req}, 16'h0);
    chk("rst_halted",    {15'b0, halted}, 16'h0);

    // Latency 1, back-to-back fetches
    rst = 1'b0;
    #1;
    chk("first_req",  {15'b0, imem_req}, 16'h1);
    chk("first_addr", imem_addr, 16'h0000);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h1234);
    cyc();
    chk("l1_v0",   {15'b0, ifid_valid}, 16'h1);
    chk("l1_i0",   ifid_instr, 16'h1234);
    chk("l1_pc0",  ifid_pc, 16'h0000);
    chk("l1_addr", imem_addr, 16'h0002);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h5678);
    cyc();
    chk("l1_i1",   ifid_instr, 16'h5678);
    chk("l1_pc1",  ifid_pc, 16'h0002);
    chk("l1_pc",   curr_addr, 16'h0004);

    // Latency 3
    do_reset();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      chk("l3_addr_wait", imem_addr, 16'h0000);
      cyc();
      chk("l3_bubble", {15'b0, ifid_valid}, 16'h0);
    end
    chk("l3_addr_last", imem_addr, 16'h0000);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h1234);
    cyc();
    chk("l3_v",   {15'b0, ifid_valid}, 16'h1);
    chk("l3_i",   ifid_instr, 16'h1234);
    chk("l3_pc",  curr_addr, 16'h0002);

    // Stall in the response cycle, held for 2 cycles
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h5678);
    cyc();
    chk("st_req0",  {15'b0, imem_req}, 16'h0);
    chk("st_i0",    ifid_instr, 16'h1234);
    chk("st_ipc0",  ifid_pc, 16'h0000);
    chk("st_pc0",   curr_addr, 16'h0002);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    cyc();
    chk("st_req1",  {15'b0, imem_req}, 16'h0);
    chk("st_i1",    ifid_instr, 16'h1234);
    chk("st_v1",    {15'b0, ifid_valid}, 16'h1);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc();
    chk("st_rel_i",   ifid_instr, 16'h5678);
    chk("st_rel_ipc", ifid_pc, 16'h0002);
    chk("st_rel_pc",  curr_addr, 16'h0004);
    chk("st_rel_req", {15'b0, imem_req}, 16'h1);

    // Redirect while request to 0006 is outstanding
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h1111);
    cyc();
    chk("rd_pc6", curr_addr, 16'h0006);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc();
    drive(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0);
    cyc();
    chk("rd_v",    {15'b0, ifid_valid}, 16'h0);
    chk("rd_addr", imem_addr, 16'h0040);
    chk("rd_req",  {15'b0, imem_req}, 16'h1);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'hDEAD);
    cyc();
    chk("rd_drop_v",  {15'b0, ifid_valid}, 16'h0);
    chk("rd_drop_pc", curr_addr, 16'h0040);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h2222);
    cyc();
    chk("rd_ipc", ifid_pc, 16'h0040);
    chk("rd_i",   ifid_instr, 16'h2222);
    chk("rd_pc",  curr_addr, 16'h0042);

    // Halt at 000A, then redirect to 0020
    drive(1'b1, 16'h000A, 1'b0, 1'b1, 16'h3333);
    cyc();
    chk("h_pcA", curr_addr, 16'h000A);
    chk("h_v0",  {15'b0, ifid_valid}, 16'h0);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'hF000);
    cyc();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      chk("h_halted", {15'b0, halted}, 16'h1);
      chk("h_req",    {15'b0, imem_req}, 16'h0);
      chk("h_pc",     curr_addr, 16'h000C);
      cyc();
    end
    chk("h_i", ifid_instr, 16'hF000);
    drive(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0);
    cyc();
    chk("h_unhalt", {15'b0, halted}, 16'h0);
    chk("h_addr20", imem_addr, 16'h0020);
    chk("h_req20",  {15'b0, imem_req}, 16'h1);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h4444);
    cyc();
    chk("h_ipc20", ifid_pc, 16'h0020);
    chk("h_i20",   ifid_instr, 16'h4444);

    // pc wrap at FFFE
    drive(1'b1, 16'hFFFE, 1'b0, 1'b1, 16'h3333);
    cyc();
    chk("w_pcFE", curr_addr, 16'hFFFE);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h5555);
    cyc();
    chk("w_pc",  curr_addr, 16'h0000);
    chk("w_ipc", ifid_pc, 16'hFFFE);

    // Redirect overrides stall on IF/ID
    drive(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0);
    cyc();
    chk("ts_v",  {15'b0, ifid_valid}, 16'h0);
    chk("ts_pc", curr_addr, 16'h0100);

    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
